barrier_seq_gen: RTL and testbench
==================================

# barrier_seq_gen

- Generates the two-barrier sensor waveforms (A, B) that the people-counter consumes: entry, exit, incomplete, and simultaneous-activation patterns.
- Each pattern runs as a timed sequence of levels on SENS_A/SENS_B and is requested through a valid/ready handshake.
- The block also keeps an expected occupancy count, so a bench or on-board self-test can compare it against the counter's LED value.
- It sits on the transmitting side of the A/B sensor interface and replaces manual button stimulus.

## Interface
- HOLD_CYCLES, 100000: clock cycles each A/B level is held (1 ms at 100 MHz); legal range 1 to 2^32-1.
- CNT_MAX, 15: saturation ceiling of EXP_CNT; must fit in 4 bits.
- CLK  in  1  system clock; rising edge active.
- RSTN  in  1  reset; asynchronous, active-low.
- REQ_VALID  in  1  a pattern request is present.
- REQ_KIND  in  2  pattern select: 00 entry, 01 exit, 10 incomplete, 11 simultaneous.
- REQ_READY  out  1  the block can accept a request.
- SENS_A  out  1  barrier A drive (BTN1 side of the counter).
- SENS_B  out  1  barrier B drive (BTN2 side of the counter).
- BUSY  out  1  a pattern is in progress.
- DONE  out  1  one-cycle pulse when a pattern completes.
- EXP_CNT  out  4  expected occupancy count after all completed patterns.

## Operation
- FSM states: IDLE, PH1, PH2, PH3, PH4.
- IDLE: SENS_A = SENS_B = 0, REQ_READY = 1, BUSY = 0.
- A request is accepted on a rising edge with REQ_VALID = 1 and REQ_READY = 1. REQ_KIND is latched at that edge; later changes on REQ_KIND are ignored.
- Phase (A,B) values per pattern:
  - Entry (00): PH1 = 10, PH2 = 11, PH3 = 01, PH4 = 00.
  - Exit (01): PH1 = 01, PH2 = 11, PH3 = 10, PH4 = 00.
  - Incomplete (10): PH1 = 10, then PH4 = 00; PH2 and PH3 are skipped.
  - Simultaneous (11): PH1 = 11, then PH4 = 00; PH2 and PH3 are skipped.
- Every phase lasts exactly HOLD_CYCLES cycles, timed by a 32-bit down-counter that reloads on each phase entry.
- PH4 always ends the pattern with a full HOLD_CYCLES of 00. This gives the counter's debouncer a settled idle level.
- At the end of PH4:
  - DONE pulses for one cycle and the FSM returns to IDLE.
  - EXP_CNT updates in the same cycle: entry gives +1 (holds at CNT_MAX), exit gives -1 (holds at 0), incomplete and simultaneous leave it unchanged.
- Back-to-back requests: REQ_READY is high in the DONE cycle. A request accepted on the edge that ends the DONE cycle starts PH1 on the next cycle, with no extra idle gap.
- Reset:
  - RSTN low forces IDLE immediately, including mid-pattern.
  - Reset values: SENS_A = 0, SENS_B = 0, BUSY = 0, DONE = 0, REQ_READY = 1, EXP_CNT = 0.
  - A pattern interrupted by reset is discarded: no DONE pulse, no count change.

## Timing
- All outputs are registered; none has a combinational path from an input.
- Acceptance edge T: BUSY = 1 and REQ_READY = 0 from cycle T+1, with SENS_A/SENS_B showing the PH1 value from T+1.
- Phase k of a pattern (k counted from 1) occupies cycles T+1+(k-1)·HOLD_CYCLES through T+k·HOLD_CYCLES.
- DONE cycle:
  - Entry/exit: DONE = 1 at cycle T+4·HOLD_CYCLES+1. BUSY = 0, REQ_READY = 1 and the new EXP_CNT are all visible in that same cycle.
  - Incomplete/simultaneous: the same applies at cycle T+2·HOLD_CYCLES+1.
- With HOLD_CYCLES = 1 every phase lasts exactly one cycle, with no skipped or doubled phases.
- REQ_VALID high while BUSY = 1 is held off by REQ_READY = 0. The request is neither lost nor queued, so the requester must keep REQ_VALID high until it is accepted.

## Test plan
Run with HOLD_CYCLES = 4 and a 10 ns clock.
- **Reset values:** reset, then one entry request. Checks:
  - Out of reset: SENS = 00, REQ_READY = 1, EXP_CNT = 0.
  - A,B sequence 10, 11, 01, 00, each exactly 4 cycles; DONE on cycle 17 after acceptance; EXP_CNT = 1.
- **Exit:** exit request after one entry. Checks: A,B sequence 01, 11, 10, 00, each 4 cycles; DONE at +17; EXP_CNT returns to 0.
- **Incomplete and simultaneous:**
  - Incomplete: 10 for 4 cycles then 00 for 4 cycles; DONE at +9; EXP_CNT unchanged.
  - Simultaneous: 11 for 4 cycles then 00 for 4 cycles; DONE at +9; EXP_CNT unchanged.
- **Saturation:**
  - 17 back-to-back entries with REQ_VALID held high: EXP_CNT saturates at 15, and each PH1 starts the cycle after the DONE-cycle acceptance.
  - Exit from EXP_CNT = 0: EXP_CNT stays 0.
- **Handshake:** toggle REQ_VALID and REQ_KIND while BUSY = 1. Checks: the running pattern is unchanged, and the pending request starts only after DONE.
- **Mid-pattern reset:** assert RSTN low during PH2 of an entry. Checks:
  - SENS = 00 at once, with no DONE pulse and EXP_CNT = 0.
  - After release, a new entry runs normally.

Source files
------------

// File: rtl/barrier_seq_gen.sv
// -----------------------------------------------------------------------------
// barrier_seq_gen
//
// Purpose:
//   Generates the two-barrier sensor waveforms (A, B) that the people-counter
//   consumes. A pattern is requested through a valid/ready handshake. It then
//   plays out as a timed sequence of A/B levels, each held for HOLD_CYCLES
//   clocks. The block also tracks the occupancy count the counter should show
//   once all completed patterns have been applied.
//
//   Patterns (REQ_KIND), given as phase values (A,B):
//     00 entry        : 10, 11, 01, 00
//     01 exit         : 01, 11, 10, 00
//     10 incomplete   : 10, 00          (PH2/PH3 skipped)
//     11 simultaneous : 11, 00          (PH2/PH3 skipped)
//
// Handshake:
//   A request is accepted on a rising clk_i edge where req_valid_i and
//   req_ready_o are both 1. req_kind_i is latched on that edge. req_ready_o is
//   low while a pattern runs. A request held during that time is neither lost
//   nor queued: the requester keeps req_valid_i high until it is accepted.
//   req_ready_o is already high in the DONE cycle, so back-to-back patterns
//   run with no idle gap.
//
// Ports:
//   clk_i        system clock, rising edge active
//   rstn_i       asynchronous active-low reset
//   req_valid_i  a pattern request is present
//   req_kind_i   pattern select (see table above)
//   req_ready_o  block can accept a request
//   sens_a_o     barrier A drive
//   sens_b_o     barrier B drive
//   busy_o       a pattern is in progress
//   done_o       one-cycle pulse when a pattern completes
//   exp_cnt_o    expected occupancy count, saturating at 0 and CNT_MAX
//   state_o      current FSM state (debug visibility)
// -----------------------------------------------------------------------------
module barrier_seq_gen #(
    parameter logic [31:0] HOLD_CYCLES = 32'd100000,
    parameter logic [3:0]  CNT_MAX     = 4'd15
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       req_valid_i,
    input  logic [1:0] req_kind_i,
    output logic       req_ready_o,
    output logic       sens_a_o,
    output logic       sens_b_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [3:0] exp_cnt_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PH1  = 3'd1,
        PH2  = 3'd2,
        PH3  = 3'd3,
        PH4  = 3'd4
    } state_e;

    localparam logic [1:0] KIND_ENTRY = 2'b00;
    localparam logic [1:0] KIND_EXIT  = 2'b01;

    // The timer counts down to zero, so each phase is loaded with HOLD_CYCLES-1
    // and lasts exactly HOLD_CYCLES cycles.
    localparam logic [31:0] RELOAD = HOLD_CYCLES - 32'd1;

    state_e      state_q,   state_d;
    logic [1:0]  kind_q,    kind_d;
    logic [31:0] timer_q,   timer_d;
    logic [3:0]  cnt_q,     cnt_d;
    logic        sens_a_q,  sens_a_d;
    logic        sens_b_q,  sens_b_d;
    logic        busy_q,    busy_d;
    logic        ready_q,   ready_d;
    logic        done_q,    done_d;

    logic        accept;
    logic        phase_end;

    // ready_q is high exactly when the FSM is in IDLE, so it can act as the
    // acceptance qualifier without adding a combinational path to req_ready_o.
    assign accept    = req_valid_i && ready_q;
    assign phase_end = (timer_q == 32'd0);

    // A/B level for a given state and pattern kind.
    function automatic logic [1:0] phase_ab(input state_e st, input logic [1:0] kind);
        logic [1:0] ab;
        ab = 2'b00;
        case (st)
            PH1: begin
                case (kind)
                    2'b00:   ab = 2'b10;
                    2'b01:   ab = 2'b01;
                    2'b10:   ab = 2'b10;
                    default: ab = 2'b11;
                endcase
            end
            PH2:     ab = 2'b11;
            PH3:     ab = (kind == KIND_EXIT) ? 2'b10 : 2'b01;
            default: ab = 2'b00;
        endcase
        return ab;
    endfunction

    // Next-state logic
    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        timer_d = timer_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = PH1;
                    kind_d  = req_kind_i;
                    timer_d = RELOAD;
                end
            end

            PH1: begin
                if (phase_end) begin
                    timer_d = RELOAD;
                    // Incomplete and simultaneous (kind[1] set) go straight to
                    // the closing idle phase.
                    state_d = kind_q[1] ? PH4 : PH2;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end

            PH2: begin
                if (phase_end) begin
                    timer_d = RELOAD;
                    state_d = PH3;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end

            PH3: begin
                if (phase_end) begin
                    timer_d = RELOAD;
                    state_d = PH4;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end

            PH4: begin
                if (phase_end) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    if (kind_q == KIND_ENTRY) begin
                        if (cnt_q < CNT_MAX) cnt_d = cnt_q + 4'd1;
                    end else if (kind_q == KIND_EXIT) begin
                        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                    end
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The outputs are computed from the next state so that, once registered,
    // they line up with the state they describe in the same cycle.
    always_comb begin
        {sens_a_d, sens_b_d} = phase_ab(state_d, kind_d);
        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= IDLE;
            kind_q   <= 2'b00;
            timer_q  <= 32'd0;
            cnt_q    <= 4'd0;
            sens_a_q <= 1'b0;
            sens_b_q <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            timer_q  <= timer_d;
            cnt_q    <= cnt_d;
            sens_a_q <= sens_a_d;
            sens_b_q <= sens_b_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
        end
    end

    assign req_ready_o = ready_q;
    assign sens_a_o    = sens_a_q;
    assign sens_b_o    = sens_b_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign exp_cnt_o   = cnt_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_barrier_seq_gen.sv
// -----------------------------------------------------------------------------
// tb_barrier_seq_gen
//
// Directed bench for barrier_seq_gen with HOLD_CYCLES = 4 and a 10 ns clock.
// Every cycle of a pattern is compared as one packed observation:
//   {A, B, BUSY, REQ_READY, DONE, EXP_CNT[3:0]}
// Observations are taken 1 ns after the rising edge, and inputs are driven at
// the same point.
// -----------------------------------------------------------------------------
module tb_barrier_seq_gen;

  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_kind = 2'b00;
  logic       req_ready;
  logic       sens_a;
  logic       sens_b;
  logic       busy;
  logic       done;
  logic [3:0] exp_cnt;
  logic [2:0] state;

  int n_vec  = 0;
  int n_miss = 0;
  logic [3:0] model_cnt = 4'd0;

  barrier_seq_gen #(
    .HOLD_CYCLES(32'd4),
    .CNT_MAX    (4'd15)
  ) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .req_valid_i(req_valid),
    .req_kind_i (req_kind),
    .req_ready_o(req_ready),
    .sens_a_o   (sens_a),
    .sens_b_o   (sens_b),
    .busy_o     (busy),
    .done_o     (done),
    .exp_cnt_o  (exp_cnt),
    .state_o    (state)
  );

  // clock
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [1:0] kind;
    logic [7:0] seq;       // PH values (A,B), first phase in [7:6]
    int         nph;       // number of phases that are actually played
    logic [3:0] cnt_after; // EXP_CNT expected in the DONE cycle
  } vec_t;

  vec_t vecs[11];

  function automatic logic [8:0] obs();
    return {sens_a, sens_b, busy, req_ready, done, exp_cnt};
  endfunction

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got {A,B,busy,rdy,done,cnt}=%b_%b_%b_%b_%b_%0d required %b_%b_%b_%b_%b_%0d",
               name, act[8], act[7], act[6], act[5], act[4], act[3:0],
               exp[8], exp[7], exp[6], exp[5], exp[4], exp[3:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Requests one pattern and checks every cycle from the acceptance edge T up
  // to and including the DONE cycle.
  //  keep_valid: REQ_VALID stays high after acceptance (back-to-back traffic)
  //  toggle    : REQ_VALID/REQ_KIND wiggle while busy, then an exit request
  //              is posted just before the pattern ends
  task automatic run_pattern(input string name, input logic [1:0] kind,
                             input logic [7:0] seq, input int nph,
                             input logic [3:0] cnt_after,
                             input bit keep_valid, input bit toggle);
    int   budget;
    logic [1:0] ab;
    logic [7:0] s;
    req_valid = 1'b1;
    req_kind  = kind;
    budget = 0;
    while (!req_ready && budget < 100) begin
      tick();
      budget++;
    end
    if (!req_ready) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s_accept: req_ready stayed 0 for 100 cycles, required 1", name);
      return;
    end
    tick();  // acceptance edge T, now in cycle T+1
    if (!keep_valid) req_valid = 1'b0;
    s = seq;
    for (int c = 1; c <= nph * H; c++) begin
      ab = s[7 - 2 * ((c - 1) / H) -: 2];
      chk($sformatf("%s_c%0d", name, c), obs(), {ab, 1'b1, 1'b0, 1'b0, model_cnt});
      if (toggle) begin
        req_valid = c[0];
        req_kind  = c[1:0];
        if (c == nph * H) begin
          req_valid = 1'b1;
          req_kind  = 2'b01;
        end
      end
      tick();
    end
    chk($sformatf("%s_done", name), obs(), {2'b00, 1'b0, 1'b1, 1'b1, cnt_after});
    model_cnt = cnt_after;
  endtask

  initial begin
    // table of directed patterns with hand-computed expected values
    vecs[0]  = '{"entry0",  2'b00, 8'b10_11_01_00, 4, 4'd1};
    vecs[1]  = '{"exit0",   2'b01, 8'b01_11_10_00, 4, 4'd0};
    vecs[2]  = '{"incomp0", 2'b10, 8'b10_00_00_00, 2, 4'd0};
    vecs[3]  = '{"simul0",  2'b11, 8'b11_00_00_00, 2, 4'd0};
    vecs[4]  = '{"exit_at0",2'b01, 8'b01_11_10_00, 4, 4'd0};
    vecs[5]  = '{"entry1",  2'b00, 8'b10_11_01_00, 4, 4'd1};
    vecs[6]  = '{"entry2",  2'b00, 8'b10_11_01_00, 4, 4'd2};
    vecs[7]  = '{"incomp1", 2'b10, 8'b10_00_00_00, 2, 4'd2};
    vecs[8]  = '{"simul1",  2'b11, 8'b11_00_00_00, 2, 4'd2};
    vecs[9]  = '{"exit1",   2'b01, 8'b01_11_10_00, 4, 4'd1};
    vecs[10] = '{"entry3",  2'b00, 8'b10_11_01_00, 4, 4'd2};

    // reset block
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_held", obs(), {2'b00, 1'b0, 1'b1, 1'b0, 4'd0});
    @(posedge clk);
    #2;
    rstn = 1'b1;
    tick();
    chk("reset_released", obs(), {2'b00, 1'b0, 1'b1, 1'b0, 4'd0});

    // table-driven patterns
    for (int i = 0; i < 11; i++) begin
      run_pattern(vecs[i].name, vecs[i].kind, vecs[i].seq, vecs[i].nph,
                  vecs[i].cnt_after, 1'b0, 1'b0);
      tick();
    end

    // 17 back-to-back entries with REQ_VALID held high: count climbs 2 -> 15
    // and then stays at 15
    for (int i = 0; i < 17; i++) begin
      logic [3:0] nxt;
      nxt = (model_cnt == 4'd15) ? 4'd15 : model_cnt + 4'd1;
      run_pattern($sformatf("sat%0d", i), 2'b00, 8'b10_11_01_00, 4, nxt, 1'b1, 1'b0);
    end
    req_valid = 1'b0;
    tick();
    chk("sat_final", obs(), {2'b00, 1'b0, 1'b1, 1'b0, 4'd15});

    // handshake: wiggle inputs while busy, then a pending exit waits for DONE
    run_pattern("hs_entry", 2'b00, 8'b10_11_01_00, 4, 4'd15, 1'b0, 1'b1);
    run_pattern("hs_exit", 2'b01, 8'b01_11_10_00, 4, 4'd14, 1'b0, 1'b0);
    tick();

    // mid-pattern reset during PH2 of an entry
    req_valid = 1'b1;
    req_kind  = 2'b00;
    tick();  // acceptance edge
    req_valid = 1'b0;
    chk("mr_ph1", obs(), {2'b10, 1'b1, 1'b0, 1'b0, 4'd14});
    repeat (5) tick();
    chk("mr_ph2", obs(), {2'b11, 1'b1, 1'b0, 1'b0, 4'd14});
    #1;
    rstn = 1'b0;
    #1;
    chk("mr_async", obs(), {2'b00, 1'b0, 1'b1, 1'b0, 4'd0});
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("mr_hold%0d", i), obs(), {2'b00, 1'b0, 1'b1, 1'b0, 4'd0});
    end
    @(posedge clk);
    #2;
    rstn = 1'b1;
    model_cnt = 4'd0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("mr_nodone%0d", i), obs(), {2'b00, 1'b0, 1'b1, 1'b0, 4'd0});
    end
    run_pattern("mr_entry", 2'b00, 8'b10_11_01_00, 4, 4'd1, 1'b0, 1'b0);
    tick();
    chk("mr_idle", obs(), {2'b00, 1'b0, 1'b1, 1'b0, 4'd1});

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1);
  end

endmodule
